// File: rtl/aes_host_seq.sv
// ============================================================================
// Module   : aes_host_seq
// Purpose  : Serialises one whole AES request onto the AES register bus and
//            returns the 128-bit result over a valid/ready handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

module aes_host_seq #(
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_encdec,
    input  logic         cmd_keylen,
    input  logic         cmd_rekey,
    input  logic [255:0] cmd_key,
    input  logic [127:0] cmd_block,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [127:0] res_data,
    output logic         res_err,
    output logic         busy,
    output logic [3:0]   aes_address,
    output logic [15:0]  aes_data_in,
    input  logic [7:0]   aes_data_out
);

    localparam int             PW          = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [PW-1:0]  c_poll_last = PW'(TIMEOUT - 1);
    localparam logic [PW-1:0]  c_rd_lat    = PW'(RD_LAT);
    localparam logic [4:0]     c_rd_lat5   = 5'(RD_LAT);
    localparam logic [4:0]     c_read_last = 5'(16 + RD_LAT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CFG, S_KEY, S_INIT, S_WRDY, S_BLK, S_NEXT, S_WVLD, S_READ, S_OUT
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [4:0]     r_cnt, w_cnt_nxt;
    logic [PW-1:0]  r_poll, w_poll_nxt;
    logic           r_encdec, r_keylen, r_rekey;
    logic [255:0]   r_key;
    logic [127:0]   r_block, r_res;
    logic           r_err, w_err_nxt, w_clr_res, w_accept;
    logic           r_cmd_ready, r_busy, r_res_valid;
    logic [3:0]     r_addr, w_addr;
    logic [15:0]    r_wdata, w_wdata, w_kword, w_bword;

    assign cmd_ready   = r_cmd_ready;
    assign busy        = r_busy;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res;
    assign res_err     = r_err;
    assign aes_address = r_addr;
    assign aes_data_in = r_wdata;

    assign w_accept = (r_state == S_IDLE) && cmd_valid;
    // Word selection uses the next count because bus outputs are registered.
    assign w_kword  = 16'(r_key >> (9'd240 - {1'b0, w_cnt_nxt[3:0], 4'b0}));
    assign w_bword  = 16'(r_block >> (8'd112 - {1'b0, w_cnt_nxt[2:0], 4'b0}));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_poll_nxt  = r_poll;
        w_err_nxt   = r_err;
        w_clr_res   = 1'b0;
        case (r_state)
            S_IDLE: if (cmd_valid) begin
                w_state_nxt = S_CFG;
                w_err_nxt   = 1'b0;
            end
            S_CFG: begin
                w_state_nxt = r_rekey ? S_KEY : S_BLK;
                w_cnt_nxt   = 5'd0;
            end
            S_KEY: if (r_cnt[3:0] == (r_keylen ? 4'd15 : 4'd7)) begin
                w_state_nxt = S_INIT;
                w_cnt_nxt   = 5'd0;
            end else begin
                w_cnt_nxt = r_cnt + 5'd1;
            end
            S_INIT: begin
                w_state_nxt = S_WRDY;
                w_poll_nxt  = '0;
            end
            S_WRDY, S_WVLD: begin
                if (r_poll >= c_rd_lat &&
                    ((r_state == S_WRDY) ? aes_data_out[0] : aes_data_out[1])) begin
                    w_state_nxt = (r_state == S_WRDY) ? S_BLK : S_READ;
                    w_cnt_nxt   = 5'd0;
                end else if (r_poll == c_poll_last) begin
                    w_state_nxt = S_OUT;
                    w_err_nxt   = 1'b1;
                    w_clr_res   = 1'b1;
                end else begin
                    w_poll_nxt = r_poll + PW'(1);
                end
            end
            S_BLK: if (r_cnt[2:0] == 3'd7) begin
                w_state_nxt = S_NEXT;
                w_cnt_nxt   = 5'd0;
            end else begin
                w_cnt_nxt = r_cnt + 5'd1;
            end
            S_NEXT: begin
                w_state_nxt = S_WVLD;
                w_poll_nxt  = '0;
            end
            S_READ: if (r_cnt == c_read_last) begin
                w_state_nxt = S_OUT;
            end else begin
                w_cnt_nxt = r_cnt + 5'd1;
            end
            S_OUT: if (res_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_addr  = 4'h0;
        w_wdata = 16'h0000;
        case (w_state_nxt)
            S_CFG:  begin w_addr = 4'h1; w_wdata = {14'b0, cmd_keylen, cmd_encdec}; end
            S_KEY:  begin w_addr = 4'h2; w_wdata = w_kword; end
            S_INIT: begin w_addr = 4'hf; w_wdata = 16'h0001; end
            S_WRDY: w_addr = 4'h4;
            S_BLK:  begin w_addr = 4'h3; w_wdata = w_bword; end
            S_NEXT: begin w_addr = 4'hf; w_wdata = 16'h0002; end
            S_WVLD: w_addr = 4'h4;
            // Only the first 16 read cycles drive; the rest drain the read pipeline.
            S_READ: w_addr = (w_cnt_nxt < 5'd16) ? 4'h5 : 4'h0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 5'd0;
            r_poll      <= '0;
            r_encdec    <= 1'b0;
            r_keylen    <= 1'b0;
            r_rekey     <= 1'b0;
            r_key       <= '0;
            r_block     <= '0;
            r_res       <= '0;
            r_err       <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
            r_addr      <= 4'h0;
            r_wdata     <= 16'h0000;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_poll      <= w_poll_nxt;
            r_err       <= w_err_nxt;
            r_cmd_ready <= (w_state_nxt == S_IDLE);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_res_valid <= (w_state_nxt == S_OUT);
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            if (w_accept) begin
                r_encdec <= cmd_encdec;
                r_keylen <= cmd_keylen;
                r_rekey  <= cmd_rekey;
                r_key    <= cmd_key;
                r_block  <= cmd_block;
            end
            if (w_clr_res) begin
                r_res <= '0;
            end else if (r_state == S_READ && r_cnt >= c_rd_lat5) begin
                r_res <= {r_res[119:0], aes_data_out};
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aes_host_seq.sv
// ============================================================================
// Module   : tb_aes_host_seq
// Purpose  : Directed self-checking bench for aes_host_seq against a small
//            table-driven AES register-core model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_aes_host_seq;

    localparam int RD_LAT  = 1;
    localparam int TIMEOUT = 16;

    localparam logic [127:0] c_k128 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] c_k256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] c_pt   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_ct1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_ct2  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] c_bad  = 128'hbad0bad0bad0bad0bad0bad0bad0bad0;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0, cmd_encdec = 1'b0, cmd_keylen = 1'b0, cmd_rekey = 1'b0;
    logic [255:0] cmd_key = '0;
    logic [127:0] cmd_block = '0;
    logic         res_ready = 1'b0;
    logic         cmd_ready, res_valid, res_err, busy;
    logic [127:0] res_data;
    logic [3:0]   aes_address;
    logic [15:0]  aes_data_in;
    logic [7:0]   aes_data_out = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    aes_host_seq #(.RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_encdec(cmd_encdec),
        .cmd_keylen(cmd_keylen), .cmd_rekey(cmd_rekey), .cmd_key(cmd_key),
        .cmd_block(cmd_block), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_err(res_err), .busy(busy),
        .aes_address(aes_address), .aes_data_in(aes_data_in), .aes_data_out(aes_data_out)
    );

    // Core model: records writes, answers polls/reads with one cycle of latency.
    logic [255:0] m_key = '0;
    logic [127:0] m_blk = '0, m_res = '0;
    logic         m_ready = 1'b0, m_valid = 1'b0, m_enc = 1'b0, m_kl = 1'b0;
    logic         stuck = 1'b0;
    int           m_ptr = 0;
    int           n_key_wr = 0, n_init_wr = 0, n_poll4 = 0;

    function automatic logic [127:0] lookup(input logic enc, input logic kl,
                                            input logic [255:0] k, input logic [127:0] b);
        if (enc && !kl && k[127:0] == c_k128 && b == c_pt)  return c_ct1;
        if (enc && kl && k == c_k256 && b == c_pt)          return c_ct2;
        if (!enc && !kl && k[127:0] == c_k128 && b == c_ct1) return c_pt;
        return c_bad;
    endfunction

    always @(posedge clk) begin
        case (aes_address)
            4'h1: {m_kl, m_enc} <= aes_data_in[1:0];
            4'h2: begin m_key <= {m_key[239:0], aes_data_in}; n_key_wr++; end
            4'h3: begin m_blk <= {m_blk[111:0], aes_data_in}; m_valid <= 1'b0; end
            4'h4: begin aes_data_out <= {6'b0, m_valid & ~stuck, m_ready}; n_poll4++; end
            4'h5: begin
                if (m_ptr < 16) aes_data_out <= m_res[127 - 8*m_ptr -: 8];
                m_ptr <= m_ptr + 1;
            end
            4'hf: begin
                if (aes_data_in == 16'h0001) begin m_ready <= 1'b1; n_init_wr++; end
                if (aes_data_in == 16'h0002) begin
                    m_valid <= 1'b1;
                    m_ptr   <= 0;
                    m_res   <= lookup(m_enc, m_kl, m_key, m_blk);
                end
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int d_key, d_init, d_poll;

    task automatic run_cmd(input logic enc, input logic kl, input logic rk,
                           input logic [255:0] key, input logic [127:0] blk, input int hold,
                           output logic [127:0] res, output logic err);
        int t;
        int k0, i0, p0;
        logic unstable;
        res = '0;
        err = 1'b1;
        @(negedge clk);
        t = 0;
        while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
        if (!cmd_ready) begin check("cmd_ready_wait", 1'b0, 1'b1); return; end
        k0 = n_key_wr; i0 = n_init_wr; p0 = n_poll4;
        cmd_encdec = enc; cmd_keylen = kl; cmd_rekey = rk;
        cmd_key = key; cmd_block = blk; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_key = '1; cmd_block = '1; cmd_encdec = ~enc; cmd_keylen = ~kl; cmd_rekey = ~rk;
        t = 0;
        while (!res_valid && t < 3000) begin @(negedge clk); t++; end
        if (!res_valid) begin check("res_valid_wait", 1'b0, 1'b1); return; end
        res = res_data;
        err = res_err;
        unstable = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (res_data !== res || res_err !== err || res_valid !== 1'b1 || cmd_ready !== 1'b0)
                unstable = 1'b1;
        end
        if (hold > 0) check("hold_stable", unstable, 1'b0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("res_valid_drop", res_valid, 1'b0);
        check("cmd_ready_back", cmd_ready, 1'b1);
        d_key = n_key_wr - k0; d_init = n_init_wr - i0; d_poll = n_poll4 - p0;
    endtask

    logic [127:0] r;
    logic         e;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_res_err", res_err, 1'b0);
        check("rst_res_data", res_data, 128'h0);
        check("rst_bus", {aes_address, aes_data_in}, 20'h0);
        rst = 1'b0;

        run_cmd(1'b1, 1'b0, 1'b1, {c_k128, 128'h0}, c_pt, 0, r, e);
        check("t1_res", r, c_ct1);
        check("t1_err", e, 1'b0);
        check("t1_key_wr", d_key, 8);
        check("t1_init_wr", d_init, 1);

        run_cmd(1'b0, 1'b0, 1'b0, 256'h0, c_ct1, 0, r, e);
        check("t3_res", r, c_pt);
        check("t3_key_wr", d_key, 0);
        check("t3_init_wr", d_init, 0);

        run_cmd(1'b1, 1'b1, 1'b1, c_k256, c_pt, 0, r, e);
        check("t2_res", r, c_ct2);
        check("t2_key_wr", d_key, 16);

        stuck = 1'b1;
        run_cmd(1'b1, 1'b1, 1'b0, 256'h0, c_pt, 0, r, e);
        stuck = 1'b0;
        check("t4_err", e, 1'b1);
        check("t4_res", r, 128'h0);
        check("t4_polls", d_poll, TIMEOUT);

        run_cmd(1'b1, 1'b1, 1'b0, 256'h0, c_pt, 10, r, e);
        check("t5_res", r, c_ct2);

        @(negedge clk);
        cmd_encdec = 1'b1; cmd_keylen = 1'b0; cmd_rekey = 1'b1;
        cmd_key = {c_k128, 128'h0}; cmd_block = c_pt; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_in_key", aes_address, 4'h2);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_addr", aes_address, 4'h0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_valid", res_valid, 1'b0);
        check("t6_rst_ready", cmd_ready, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_cmd(1'b1, 1'b0, 1'b1, {c_k128, 128'h0}, c_pt, 0, r, e);
        check("t6_res", r, c_ct1);
        check("t6_err", e, 1'b0);
        check("t6_key_wr", d_key, 8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
